uart_cfg: RTL

Runtime-configurable UART: a parametrised successor to the fixed-format 8N1 UART top. It adds per-frame selectable data length (5–8), optional even/odd parity, 1 or 2 stop bits, a runtime baud divisor, per-word receive error flags, false-start rejection and a sticky overrun flag. It sits on the system bus side with the same FIFO read/write handshake, and it instantiates the team's `fifo` block for both directions.

---
 rtl/uart_cfg.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable UART (5-8 data bits, optional parity, 1/2 stop bits, baud divisor)
// with RX/TX FIFOs, per-word error flags, false-start rejection and sticky overrun.
module fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] r_data,
  output logic          empty,
  output logic          full
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr_ok, rd_ok;
  assign empty = (cnt_q == '0);
  assign full = cnt_q[AW];
  assign r_data = mem[rp_q];
  always_comb begin
    wr_ok = wr & ~full;
    rd_ok = rd & ~empty;
    wp_d = wp_q + AW'(wr_ok);
    rp_d = rp_q + AW'(rd_ok);
    cnt_d = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end
  always_ff @(posedge clk) if (wr_ok) mem[wp_q] <= w_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
endmodule

module uart_cfg #(
  parameter int FIFO_W = 2,
  parameter int DVSR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        dbit_sel,
  input  logic              par_en,
  input  logic              par_odd,
  input  logic              stop2,
  input  logic              rx,
  output logic              tx,
  input  logic              rd_uart,
  input  logic              wr_uart,
  input  logic [7:0]        w_data,
  output logic [7:0]        r_data,
  output logic              r_par_err,
  output logic              r_frm_err,
  output logic              rx_empty,
  output logic              tx_full,
  output logic              tx_idle,
  output logic              rx_ovr,
  input  logic              clr_ovr
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} st_t;
  logic [DVSR_W-1:0] bc_q, bc_d;
  logic tick;
  st_t tst_q, tst_d, rst_q, rst_d;
  logic [4:0] ts_q, ts_d;
  logic [3:0] rs_q, rs_d;
  logic [2:0] tn_q, tn_d, rn_q, rn_d;
  logic [7:0] tsh_q, tsh_d, rsh_q, rsh_d, tx_head;
  logic [1:0] tds_q, tds_d, rds_q, rds_d;
  logic tpe_q, tpe_d, tpb_q, tpb_d, ts2_q, ts2_d, tx_q, tx_d;
  logic rpe_q, rpe_d, rpo_q, rpo_d, rperr_q, rperr_d, ovr_q, ovr_d;
  logic tx_done, tx_empty, rx_done, rx_full;
  assign tx = tx_q;
  assign rx_ovr = ovr_q;
  assign tx_idle = (tst_q == IDLE) & tx_empty;
  assign tick = (bc_q >= dvsr);
  assign bc_d = tick ? '0 : bc_q + 1'b1;
  // TX: tx_q is registered from the current state, so the line lags the FSM by one clock
  always_comb begin
    tst_d = tst_q;
    ts_d = ts_q;
    tn_d = tn_q;
    tsh_d = tsh_q;
    tds_d = tds_q;
    tpe_d = tpe_q;
    tpb_d = tpb_q;
    ts2_d = ts2_q;
    tx_done = 1'b0;
    tx_d = (tst_q == START) ? 1'b0 : (tst_q == DATA) ? tsh_q[0] : (tst_q == PAR) ? tpb_q : 1'b1;
    case (tst_q)
      IDLE: if (!tx_empty) begin
        tst_d = START;
        ts_d = '0;
        tsh_d = tx_head;
        tds_d = dbit_sel;
        tpe_d = par_en;
        ts2_d = stop2;
        tpb_d = ^(tx_head & (8'hff >> (2'd3 - dbit_sel))) ^ par_odd;
      end
      START: if (tick) begin
        ts_d = (ts_q == 5'd15) ? '0 : ts_q + 5'd1;
        tn_d = '0;
        tst_d = (ts_q == 5'd15) ? DATA : START;
      end
      DATA: if (tick) begin
        ts_d = (ts_q == 5'd15) ? '0 : ts_q + 5'd1;
        if (ts_q == 5'd15) begin
          tsh_d = tsh_q >> 1;
          tn_d = tn_q + 3'd1;
          tst_d = (tn_q != {1'b1, tds_q}) ? DATA : tpe_q ? PAR : STOP;
        end
      end
      PAR: if (tick) begin
        ts_d = (ts_q == 5'd15) ? '0 : ts_q + 5'd1;
        tst_d = (ts_q == 5'd15) ? STOP : PAR;
      end
      STOP: if (tick) begin
        ts_d = ts_q + 5'd1;
        tx_done = (ts_q == {ts2_q, 4'hf});
        tst_d = tx_done ? IDLE : STOP;
      end
      default: tst_d = IDLE;
    endcase
  end
  // RX: data bits shift in from the top; the word is right-justified when pushed
  always_comb begin
    rst_d = rst_q;
    rs_d = rs_q;
    rn_d = rn_q;
    rsh_d = rsh_q;
    rds_d = rds_q;
    rpe_d = rpe_q;
    rpo_d = rpo_q;
    rperr_d = rperr_q;
    rx_done = 1'b0;
    case (rst_q)
      IDLE: if (!rx) begin
        rst_d = START;
        rs_d = '0;
        rsh_d = '0;
        rperr_d = 1'b0;
        rds_d = dbit_sel;
        rpe_d = par_en;
        rpo_d = par_odd;
      end
      START: if (tick) begin
        rs_d = (rs_q == 4'd7) ? '0 : rs_q + 4'd1;
        rn_d = '0;
        rst_d = (rs_q != 4'd7) ? START : rx ? IDLE : DATA;
      end
      DATA: if (tick) begin
        rs_d = rs_q + 4'd1;
        if (rs_q == 4'd15) begin
          rsh_d = {rx, rsh_q[7:1]};
          rn_d = rn_q + 3'd1;
          rst_d = (rn_q != {1'b1, rds_q}) ? DATA : rpe_q ? PAR : STOP;
        end
      end
      PAR: if (tick) begin
        rs_d = rs_q + 4'd1;
        if (rs_q == 4'd15) begin
          rperr_d = ((^rsh_q) ^ rx) != rpo_q;
          rst_d = STOP;
        end
      end
      STOP: if (tick) begin
        rs_d = rs_q + 4'd1;
        rx_done = (rs_q == 4'd15);
        rst_d = rx_done ? IDLE : STOP;
      end
      default: rst_d = IDLE;
    endcase
    ovr_d = (rx_done & rx_full) | (ovr_q & ~clr_ovr);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bc_q <= '0;
      tst_q <= IDLE;
      ts_q <= '0;
      tn_q <= '0;
      tsh_q <= '0;
      tds_q <= '0;
      tpe_q <= 1'b0;
      tpb_q <= 1'b0;
      ts2_q <= 1'b0;
      tx_q <= 1'b1;
      rst_q <= IDLE;
      rs_q <= '0;
      rn_q <= '0;
      rsh_q <= '0;
      rds_q <= '0;
      rpe_q <= 1'b0;
      rpo_q <= 1'b0;
      rperr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      bc_q <= bc_d;
      tst_q <= tst_d;
      ts_q <= ts_d;
      tn_q <= tn_d;
      tsh_q <= tsh_d;
      tds_q <= tds_d;
      tpe_q <= tpe_d;
      tpb_q <= tpb_d;
      ts2_q <= ts2_d;
      tx_q <= tx_d;
      rst_q <= rst_d;
      rs_q <= rs_d;
      rn_q <= rn_d;
      rsh_q <= rsh_d;
      rds_q <= rds_d;
      rpe_q <= rpe_d;
      rpo_q <= rpo_d;
      rperr_q <= rperr_d;
      ovr_q <= ovr_d;
    end
  fifo #(.DW(8), .AW(FIFO_W)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .rd(tx_done), .wr(wr_uart), .w_data(w_data),
    .r_data(tx_head), .empty(tx_empty), .full(tx_full)
  );
  fifo #(.DW(10), .AW(FIFO_W)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .rd(rd_uart), .wr(rx_done),
    .w_data({~rx, rperr_q, rsh_q >> (2'd3 - rds_q)}),
    .r_data({r_frm_err, r_par_err, r_data}), .empty(rx_empty), .full(rx_full)
  );
endmodule
